// File: rtl/ao222_rr_arbiter.sv
// Round-robin owner selection for a shared AO222 3-way AND-OR bus mux.
// Drives a one-hot enable per leg with break-before-make gaps and optional hold timeout.
module ao222_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic       DONE,
  output logic [2:0] SEL,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TMO
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};
  localparam logic [1:0]       GAP_LAST  = 2'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [1:0]       NO_OWNER  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       gap_q, gap_d;
  logic             pend_q, pend_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;

  logic [2:0] win_ptr, win_rel;
  logic [1:0] rel_ptr;
  logic       hold_expired, rel, gr_en;
  logic [1:0] gr_idx;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic req_of(input logic [2:0] req, input logic [1:0] idx);
    case (idx)
      2'd0:    return req[0];
      2'd1:    return req[1];
      2'd2:    return req[2];
      default: return 1'b0;
    endcase
  endfunction

  // Returns {found, index} for the first request at or after ptr, wrapping mod 3.
  function automatic logic [2:0] arb_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] p;
    logic [2:0] res;
    p   = ptr;
    res = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (!res[2] && req_of(req, p)) res = {1'b1, p};
      p = inc3(p);
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign win_ptr      = arb_pick(REQ, ptr_q);
  assign rel_ptr      = inc3(owner_q);
  assign win_rel      = arb_pick(REQ, rel_ptr);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign rel          = DONE || !req_of(REQ, owner_q) || hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    gr_en   = 1'b0;
    gr_idx  = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          gr_en  = 1'b1;
          gr_idx = owner_q;
        end else if (win_ptr[2]) begin
          gr_en  = 1'b1;
          gr_idx = win_ptr[1:0];
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          ptr_d  = rel_ptr;
          sel_d  = 3'b000;
          gnt_d  = NO_OWNER;
          hold_d = '0;
          tmo_d  = hold_expired && !DONE && req_of(REQ, owner_q);
          if (GAP == 0) begin
            // Winner is picked now but only driven after one dead cycle.
            state_d = ST_IDLE;
            pend_d  = win_rel[2];
            busy_d  = win_rel[2];
            if (win_rel[2]) owner_d = win_rel[1:0];
          end else begin
            state_d = ST_GAP;
            gap_d   = 2'd0;
            busy_d  = 1'b1;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (win_ptr[2]) begin
            gr_en  = 1'b1;
            gr_idx = win_ptr[1:0];
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'b000;
        gnt_d   = NO_OWNER;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    if (gr_en) begin
      state_d = ST_GRANT;
      owner_d = gr_idx;
      sel_d   = onehot3(gr_idx);
      gnt_d   = gr_idx;
      busy_d  = 1'b1;
      hold_d  = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      hold_q  <= '0;
      gap_q   <= 2'd0;
      pend_q  <= 1'b0;
      sel_q   <= 3'b000;
      gnt_q   <= NO_OWNER;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign SEL    = sel_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = busy_q;
  assign TMO    = tmo_q;

endmodule

// File: tb/tb_ao222_rr_arbiter.sv
// Directed bench for ao222_rr_arbiter: one instance with a gap of 1 and MAX_HOLD=4,
// a second with a gap of 0 for the back-to-back handover case.
module tb_ao222_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, done_a, rst_b, done_b;
  logic [2:0] req_a, req_b;
  logic [2:0] sel_a, sel_b;
  logic [1:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, tmo_a, tmo_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ao222_rr_arbiter #(.MAX_HOLD(4), .GAP(1), .CNT_W(8)) dut_a (
    .CLK(clk), .RST(rst_a), .REQ(req_a), .DONE(done_a),
    .SEL(sel_a), .GNT_ID(gnt_a), .BUSY(busy_a), .TMO(tmo_a)
  );

  ao222_rr_arbiter #(.MAX_HOLD(4), .GAP(0), .CNT_W(8)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ(req_b), .DONE(done_b),
    .SEL(sel_b), .GNT_ID(gnt_b), .BUSY(busy_b), .TMO(tmo_b)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] s, input logic [1:0] g,
                       input logic b, input logic t);
    chk({tag, "_sel"}, {1'b0, sel_a}, {1'b0, s});
    chk({tag, "_gnt"}, {2'b00, gnt_a}, {2'b00, g});
    chk({tag, "_busy"}, {3'b000, busy_a}, {3'b000, b});
    chk({tag, "_tmo"}, {3'b000, tmo_a}, {3'b000, t});
  endtask

  always @(negedge clk) begin
    chk("onehot_a", {3'b000, $onehot0(sel_a)}, 4'd1);
    chk("onehot_b", {3'b000, $onehot0(sel_b)}, 4'd1);
  end

  logic [2:0] rot_sel [4];
  logic [1:0] rot_id  [4];

  initial begin
    rot_sel[0] = 3'b001; rot_id[0] = 2'd0;
    rot_sel[1] = 3'b010; rot_id[1] = 2'd1;
    rot_sel[2] = 3'b100; rot_id[2] = 2'd2;
    rot_sel[3] = 3'b001; rot_id[3] = 2'd0;

    rst_a = 1'b1; req_a = 3'b000; done_a = 1'b0;
    rst_b = 1'b1; req_b = 3'b000; done_b = 1'b0;
    tick(); tick();
    chk_a("reset", 3'b000, 2'd3, 1'b0, 1'b0);
    rst_a = 1'b0;
    tick();
    chk_a("idle", 3'b000, 2'd3, 1'b0, 1'b0);

    // Single request, DONE release, one gap cycle, then idle.
    req_a = 3'b001;
    tick();
    chk_a("t1_grant", 3'b001, 2'd0, 1'b1, 1'b0);
    done_a = 1'b1;
    tick();
    chk_a("t1_gap", 3'b000, 2'd3, 1'b1, 1'b0);
    done_a = 1'b0; req_a = 3'b000;
    tick();
    chk_a("t1_idle", 3'b000, 2'd3, 1'b0, 1'b0);

    // Rotation 0,1,2,0 with all requesting and DONE on every third grant cycle.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; req_a = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_a($sformatf("t2_grant%0d", k), rot_sel[k], rot_id[k], 1'b1, 1'b0);
      tick();
      chk($sformatf("t2_hold2_%0d", k), {1'b0, sel_a}, {1'b0, rot_sel[k]});
      tick();
      chk($sformatf("t2_hold3_%0d", k), {1'b0, sel_a}, {1'b0, rot_sel[k]});
      done_a = 1'b1;
      if (k == 3) req_a = 3'b000;
      tick();
      chk_a($sformatf("t2_gap%0d", k), 3'b000, 2'd3, 1'b1, 1'b0);
      done_a = 1'b0;
      tick();
    end
    chk_a("t2_idle", 3'b000, 2'd3, 1'b0, 1'b0);

    // Timeout: PTR is 1, source 1 alone holds for 4 cycles, TMO, gap, regrant.
    req_a = 3'b010;
    tick();
    chk_a("t3_grant", 3'b010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a($sformatf("t3_hold%0d", k + 2), 3'b010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk_a("t3_tmo", 3'b000, 2'd3, 1'b1, 1'b1);
    tick();
    chk_a("t3_regrant", 3'b010, 2'd1, 1'b1, 1'b0);

    // DONE coincident with the timeout cycle suppresses TMO.
    tick(); tick(); tick();
    chk("t4_hold4", {1'b0, sel_a}, 4'b0010);
    done_a = 1'b1;
    tick();
    chk_a("t4_done_tmo", 3'b000, 2'd3, 1'b1, 1'b0);
    done_a = 1'b0; req_a = 3'b000;
    tick();
    chk_a("t4_idle", 3'b000, 2'd3, 1'b0, 1'b0);

    // Request drop mid-grant releases on the next edge without TMO.
    req_a = 3'b100;
    tick();
    chk_a("t4_grant2", 3'b100, 2'd2, 1'b1, 1'b0);
    tick();
    chk("t4_hold2", {1'b0, sel_a}, 4'b0100);
    req_a = 3'b000;
    tick();
    chk_a("t4_drop", 3'b000, 2'd3, 1'b1, 1'b0);
    tick();
    chk_a("t4_idle2", 3'b000, 2'd3, 1'b0, 1'b0);

    // Reset during a grant clears without a gap, then PTR=0 picks source 1 from 110.
    req_a = 3'b100;
    tick();
    chk_a("t6_grant", 3'b100, 2'd2, 1'b1, 1'b0);
    rst_a = 1'b1;
    tick();
    chk_a("t6_reset", 3'b000, 2'd3, 1'b0, 1'b0);
    rst_a = 1'b0; req_a = 3'b110;
    tick();
    chk_a("t6_after", 3'b010, 2'd1, 1'b1, 1'b0);
    req_a = 3'b000;
    tick(); tick();

    // Zero-gap handover: owner 0 releases, one dead cycle, then source 1.
    rst_b = 1'b0; req_b = 3'b011;
    tick();
    chk("t5_sel0", {1'b0, sel_b}, 4'b0001);
    chk("t5_gnt0", {2'b00, gnt_b}, 4'd0);
    done_b = 1'b1;
    tick();
    chk("t5_dead", {1'b0, sel_b}, 4'b0000);
    chk("t5_dead_gnt", {2'b00, gnt_b}, 4'd3);
    done_b = 1'b0;
    tick();
    chk("t5_sel1", {1'b0, sel_b}, 4'b0010);
    chk("t5_gnt1", {2'b00, gnt_b}, 4'd1);
    chk("t5_tmo", {3'b000, tmo_b}, 4'd0);
    req_b = 3'b000;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
